// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates I-cache and D-cache line traffic onto one shared memory port
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst           synchronous reset, active-low
//   i_pmem_read   I-cache line-fill request, held until i_pmem_resp
//   i_pmem_addr   I-cache line address
//   i_pmem_rdata  I-cache fill data, mem_rdata while I owns the port, else 0
//   i_pmem_resp   one-cycle completion pulse to the I-cache
//   d_pmem_read   D-cache fill request, held until d_pmem_resp
//   d_pmem_write  D-cache write-back request, held until d_pmem_resp
//   d_pmem_addr   D-cache line address
//   d_pmem_wdata  D-cache write-back line
//   d_pmem_rdata  D-cache fill data, mem_rdata while D owns the port, else 0
//   d_pmem_resp   one-cycle completion pulse to the D-cache
//   mem_read      shared-port read strobe
//   mem_write     shared-port write strobe
//   mem_addr      address latched at grant time
//   mem_wdata     write data latched at grant time
//   mem_rdata     line returned by memory
//   mem_resp      memory completion pulse

module cache_arbiter #(
  parameter int LINE_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D_RD,
    SERVE_D_WR,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic d_req;
  logic i_forced;
  logic serving_i;
  logic serving_d;

  assign d_req    = d_pmem_read | d_pmem_write;
  // I has waited through STARVE_LIMIT consecutive D grants: it must win this time.
  assign i_forced = i_pmem_read && (starve_cnt_q == STARVE_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          addr_d = d_pmem_addr;
          // A pending write-back goes before a fill; the fill stays requested.
          if (d_pmem_write) begin
            state_d = SERVE_D_WR;
            wdata_d = d_pmem_wdata;
          end else begin
            state_d = SERVE_D_RD;
          end
          // Cannot overflow: at STARVE_MAX with I waiting, I is forced instead.
          if (i_pmem_read && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end else if (i_pmem_read) begin
          state_d      = SERVE_I;
          addr_d       = i_pmem_addr;
          starve_cnt_d = '0;
        end
      end

      SERVE_I, SERVE_D_RD, SERVE_D_WR: begin
        if (mem_resp) begin
          state_d = DONE;
        end
      end

      // One dead cycle so the requester can drop its request before re-arbitration.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign serving_i = (state_q == SERVE_I);
  assign serving_d = (state_q == SERVE_D_RD) || (state_q == SERVE_D_WR);

  assign mem_read  = serving_i || (state_q == SERVE_D_RD);
  assign mem_write = (state_q == SERVE_D_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Responses are combinational from mem_resp so the owner sees data the cycle it arrives.
  assign i_pmem_resp  = serving_i && mem_resp;
  assign d_pmem_resp  = serving_d && mem_resp;
  assign i_pmem_rdata = serving_i ? mem_rdata : '0;
  assign d_pmem_rdata = serving_d ? mem_rdata : '0;

  a_one_strobe: assert property (@(posedge clk) !(mem_read && mem_write));
  a_one_resp:   assert property (@(posedge clk) !(i_pmem_resp && d_pmem_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_addr;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_addr;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D fill, 3 D write-back, 4 done gap)
  int            m_owner;
  int            m_starve;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  initial begin
    m_owner = 0; m_starve = 0; m_addr = '0; m_wdata = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_owner = 0; m_starve = 0; m_addr = '0; m_wdata = '0;
      end else if (m_owner == 4) begin
        m_owner = 0;
      end else if (m_owner != 0) begin
        if (mem_resp) m_owner = 4;
      end else if ((d_pmem_read || d_pmem_write) && !(i_pmem_read && m_starve == SL)) begin
        m_addr = d_pmem_addr;
        if (d_pmem_write) begin
          m_owner = 3;
          m_wdata = d_pmem_wdata;
        end else begin
          m_owner = 2;
        end
        if (i_pmem_read && m_starve < SL) m_starve = m_starve + 1;
      end else if (i_pmem_read) begin
        m_owner = 1;
        m_addr  = i_pmem_addr;
        m_starve = 0;
      end
    end
  end

  // Compare process plus grant recorder (1 I, 2 D fill, 3 D write-back)
  bit            chk_en = 1'b0;
  int            grants[$];
  logic [LW-1:0] wcap;

  initial begin
    bit prev;
    bit cur;
    prev = 1'b0;
    wcap = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_bit("mem_read", mem_read, (m_owner == 1) || (m_owner == 2));
        check_bit("mem_write", mem_write, m_owner == 3);
        check_vec("mem_addr", LW'(mem_addr), LW'(m_addr));
        check_vec("mem_wdata", mem_wdata, m_wdata);
        check_bit("i_pmem_resp", i_pmem_resp, (m_owner == 1) && mem_resp);
        check_bit("d_pmem_resp", d_pmem_resp, ((m_owner == 2) || (m_owner == 3)) && mem_resp);
        check_vec("i_pmem_rdata", i_pmem_rdata, (m_owner == 1) ? mem_rdata : '0);
        check_vec("d_pmem_rdata", d_pmem_rdata, ((m_owner == 2) || (m_owner == 3)) ? mem_rdata : '0);
        cur = mem_read || mem_write;
        if (cur && !prev) begin
          grants.push_back(mem_write ? 3 : (mem_addr[31] ? 2 : 1));
          if (mem_write) wcap = mem_wdata;
        end
        prev = cur;
      end
    end
  end

  // Stimulus: one process drives every input; step() advances one cycle.
  bit            mem_auto;
  int            mem_lat;
  int            mcnt;
  int            rsp_n;
  bit            force_resp;
  bit            d_sticky;
  bit            i_seen, d_seen, d_seen_wr;
  logic [LW-1:0] i_cap, d_cap;

  task automatic step();
    logic [31:0] word;
    @(posedge clk);
    #1;
    if (i_seen) i_pmem_read = 1'b0;
    if (d_seen) begin
      if (d_seen_wr) d_pmem_write = 1'b0;
      else if (!d_sticky) d_pmem_read = 1'b0;
    end
    i_seen = 1'b0;
    d_seen = 1'b0;
    mem_resp = force_resp;
    if (mem_auto && (mem_read || mem_write)) begin
      mcnt++;
      if (mcnt == mem_lat) begin
        mcnt = 0;
        rsp_n++;
        word = 32'hC0DE_0000 + 32'(rsp_n);
        mem_rdata = {8{word}};
        mem_resp = 1'b1;
      end
    end else begin
      mcnt = 0;
    end
    #1;
    if (i_pmem_resp) begin i_seen = 1'b1; i_cap = i_pmem_rdata; end
    if (d_pmem_resp) begin d_seen = 1'b1; d_seen_wr = mem_write; d_cap = d_pmem_rdata; end
  endtask

  task automatic wait_side(input bit want_i, input string name, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(want_i ? i_seen : d_seen) && cyc < 100);
    if (!(want_i ? i_seen : d_seen)) check_bit(name, 1'b0, 1'b1);
  endtask

  task automatic check_grants(input string name, input int exp[$]);
    int got;
    check_vec({name, "_count"}, LW'(grants.size()), LW'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      got = (k < grants.size()) ? grants[k] : -1;
      check_vec(name, LW'(got), LW'(exp[k]));
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] w;
    rst = 1'b0;
    i_pmem_read = 1'b0; i_pmem_addr = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    mem_auto = 1'b1; mem_lat = 5; mcnt = 0; rsp_n = 0; force_resp = 1'b0; d_sticky = 1'b0;
    i_seen = 1'b0; d_seen = 1'b0; d_seen_wr = 1'b0; i_cap = '0; d_cap = '0;

    step();
    chk_en = 1'b1;
    step();
    check_bit("rst_mem_read", mem_read, 1'b0);
    check_bit("rst_mem_write", mem_write, 1'b0);
    check_vec("rst_mem_addr", LW'(mem_addr), '0);
    check_vec("rst_mem_wdata", mem_wdata, '0);
    check_bit("rst_i_resp", i_pmem_resp, 1'b0);
    check_bit("rst_d_resp", d_pmem_resp, 1'b0);
    rst = 1'b1;
    step();

    // Lone I fill
    i_pmem_addr = 32'h0000_1000;
    i_pmem_read = 1'b1;
    step();
    check_bit("t1_strobe", mem_read, 1'b1);
    check_vec("t1_addr", LW'(mem_addr), LW'(32'h0000_1000));
    wait_side(1'b1, "t1_timeout", cyc);
    check_vec("t1_latency", LW'(cyc), LW'(4));
    w = 32'hC0DE_0001;
    check_vec("t1_rdata", i_cap, {8{w}});
    step();
    check_bit("t1_done_read", mem_read, 1'b0);
    check_bit("t1_done_resp", i_pmem_resp, 1'b0);
    step();

    // I and D together: D first, then I
    grants.delete();
    i_pmem_addr = 32'h0000_2000; i_pmem_read = 1'b1;
    d_pmem_addr = 32'h8000_0100; d_pmem_read = 1'b1;
    wait_side(1'b1, "t2_timeout", cyc);
    step(); step();
    check_grants("t2_order", '{2, 1});

    // Continuous D with I pending: four D grants then I is forced
    grants.delete();
    d_sticky = 1'b1;
    d_pmem_addr = 32'h8000_0200; d_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_2040; i_pmem_read = 1'b1;
    wait_side(1'b1, "t3_i_timeout", cyc);
    d_sticky = 1'b0;
    wait_side(1'b0, "t3_d_timeout", cyc);
    step(); step();
    check_grants("t3_order", '{2, 2, 2, 2, 1, 2});

    // D write-back and fill together: write first
    grants.delete();
    d_pmem_addr = 32'h8000_0300;
    d_pmem_wdata = {32{8'hA5}};
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    wait_side(1'b0, "t4_wr_timeout", cyc);
    check_bit("t4_first_is_write", d_seen_wr, 1'b1);
    wait_side(1'b0, "t4_rd_timeout", cyc);
    check_bit("t4_second_is_read", d_seen_wr, 1'b0);
    w = 32'hC0DE_000B;
    check_vec("t4_rdata", d_cap, {8{w}});
    step(); step();
    check_grants("t4_order", '{3, 2});
    check_vec("t4_wdata", wcap, {32{8'hA5}});

    // Reset while a write-back waits on memory; stray mem_resp afterwards
    mem_auto = 1'b0;
    d_pmem_addr = 32'h8000_0400;
    d_pmem_wdata = {8{32'h1234_5678}};
    d_pmem_write = 1'b1;
    step();
    check_bit("t5_write_strobe", mem_write, 1'b1);
    step(); step();
    rst = 1'b0;
    step();
    check_bit("t5_rst_write", mem_write, 1'b0);
    check_bit("t5_rst_resp", d_pmem_resp, 1'b0);
    check_vec("t5_rst_addr", LW'(mem_addr), '0);
    d_pmem_write = 1'b0;
    step();
    rst = 1'b1;
    step();
    force_resp = 1'b1;
    step();
    force_resp = 1'b0;
    check_bit("t5_stray_i_resp", i_pmem_resp, 1'b0);
    check_bit("t5_stray_d_resp", d_pmem_resp, 1'b0);
    step();
    check_bit("t5_idle_read", mem_read, 1'b0);
    check_bit("t5_idle_write", mem_write, 1'b0);

    // Requester address changes mid-transaction
    mem_auto = 1'b1; mem_lat = 4;
    i_pmem_addr = 32'h0000_3000; i_pmem_read = 1'b1;
    step();
    check_bit("t6_strobe", mem_read, 1'b1);
    i_pmem_addr = 32'h0000_3F00;
    cyc = 0;
    do begin
      step();
      cyc++;
      check_vec("t6_addr_hold", LW'(mem_addr), LW'(32'h0000_3000));
    end while (!i_seen && cyc < 20);
    check_bit("t6_resp_seen", i_seen, 1'b1);
    step();
    check_vec("t6_addr_done", LW'(mem_addr), LW'(32'h0000_3000));
    check_bit("t6_done_read", mem_read, 1'b0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
